prom_read_arbiter: RTL and testbench
====================================

Name: prom_read_arbiter

Overview:
- Shares one synchronous PROM (enable/address in, data_out registered, 1-cycle read latency) between two burst-read requesters.
- Arbitrates round-robin, then sequences consecutive PROM addresses for the granted burst.
- Returns each word with a per-requester valid strobe and signals burst completion.
- Sits between the PROM instance and its two client blocks.

Parameters:
- ADDR_W, 4, PROM address width; address wraps modulo 2^ADDR_W.
- DATA_W, 4, PROM data width.
- LEN_W, 3, burst length field width; burst = len+1 words (1..2^LEN_W).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 burst request; level, held until gnt0.
- addr0  in  ADDR_W  requester 0 start address; sampled on grant.
- len0  in  LEN_W  requester 0 burst length minus one; sampled on grant.
- req1, addr1, len1  in  1/ADDR_W/LEN_W  same for requester 1.
- gnt0, gnt1  out  1  one-cycle grant pulse.
- rvalid0, rvalid1  out  1  read data valid for the requester.
- rdata  out  DATA_W  read data, shared; qualified by rvalid0/rvalid1.
- done0, done1  out  1  one-cycle pulse coincident with the last rvalid of a burst.
- busy  out  1  high from grant until done inclusive.
- rom_enable  out  1  to PROM enable.
- rom_address  out  ADDR_W  to PROM address.
- rom_data  in  DATA_W  from PROM data_out.

Behaviour:
- All outputs are registered. Reset (async, any state) clears all of them to 0, sets the state to IDLE and the priority pointer to requester 0, and abandons any burst in flight with no done pulse.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - If any req is high, grant the winner: gnt pulses in the next cycle, addr/len are captured, and the state goes to BURST.
  - Winner is the only requester asserting req. If both assert, the winner is the one the pointer selects.
- BURST:
  - Each cycle: rom_enable=1, rom_address=cur; cur increments with wrap (4'hF -> 4'h0); remaining count decrements.
  - The cycle issuing the final address goes to DRAIN next.
  - gnt is high in the first BURST cycle.
- DRAIN:
  - Stays until the last word has been returned, then goes to IDLE.
  - rom_enable=0 and rom_address holds its last value.
- Data latency:
  - An address issued in cycle t is valid on rom_data in cycle t+1.
  - rdata and rvalidN are registered from it and valid in cycle t+2.
  - Words return strictly in address order, one per cycle, no gaps.
- done/busy/pointer:
  - doneN is asserted with the last rvalidN.
  - busy falls the cycle after done.
  - The pointer moves to the other requester when done asserts.
  - At least one IDLE cycle separates bursts, so there is no back-to-back grant.
- Request handling:
  - req is ignored while busy. A requester must drop req after its gnt; a req still high in IDLE is treated as a new request.
  - addr/len changes after grant have no effect.
- Only one of rvalid0/rvalid1 may be high in any cycle.

Test Plan:
- The bench uses a behavioural PROM model with mem[a] = ~a.
- Single burst: req0, addr0=4'h2, len0=3 -> gnt0 the cycle after req. rom_address 2,3,4,5 on 4 consecutive cycles. rvalid0 with rdata D,C,B,A starting 2 cycles after the first address. done0 with rdata=A. busy drops the next cycle.
- Wrap-around: req1, addr1=4'hE, len1=2 -> rom_address E,F,0 and rdata 1,0,F. done1 on rdata=F.
- Simultaneous requests after reset: req0 and req1 both high -> requester 0 is granted first. After done0, requester 1 is granted. A second simultaneous pair is granted 0 again, since the pointer returned to 0 after requester 1 completed.
- Single-word burst: len0=0, addr0=4'h5 -> one rom_enable cycle at address 5. rvalid0 and done0 are in the same cycle with rdata=A.
- Request during busy: req1 rises mid-burst of requester 0 -> no gnt1 until requester 0 is done. gnt1 follows after one IDLE cycle. rvalid1 never overlaps rvalid0.
- Reset mid-burst: assert reset during the third word of an 8-word burst -> all outputs 0 immediately, with no done pulse. After release, a new req0 with addr0=4'h0 and len0=0 completes normally with rdata=F.

Source files
------------

// File: rtl/prom_read_arbiter.sv
// prom_read_arbiter
// Shares one synchronous PROM between two burst-read requesters.
// A round-robin arbiter grants one burst at a time. The granted burst is
// sequenced over consecutive PROM addresses, which wrap at the top of the
// address space. Each returned word is tagged with a per-requester valid
// strobe, and done pulses on the last word.
//
// Timing of one burst (t = first BURST cycle):
//   t        : gnt, busy, rom_enable, rom_address = start
//   t+k      : rom_address = start+k (k = 0..len)
//   t+k+1    : rom_data holds word k (PROM read latency)
//   t+k+2    : rdata / rvalidN hold word k
//   t+len+2  : last word, doneN; the pointer moves to the other requester
//   t+len+3  : IDLE, busy low; the earliest next grant is t+len+4
module prom_read_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int LEN_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [LEN_W-1:0]  len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              done0,
    output logic              done1,
    output logic              busy,
    output logic              rom_enable,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nx;

    // ptr: requester favoured when both request at once.
    // owner: requester holding the current burst.
    logic              ptr, ptr_nx;
    logic              owner, owner_nx;

    // Addresses still to issue after the one currently on rom_address.
    logic [LEN_W-1:0]  remaining, remaining_nx;

    logic              rom_enable_nx;
    logic [ADDR_W-1:0] rom_address_nx;
    logic              gnt0_nx, gnt1_nx;
    logic              busy_nx;

    // Requester that would win a grant this cycle.
    logic              win;

    // The address on rom_address this cycle is the last one of the burst.
    logic              last_issue;

    // Return pipeline: a read was issued last cycle, so rom_data is valid
    // now. rd_last marks that this word is the last one of the burst.
    logic              rd_pend;
    logic              rd_last;

    // A lone requester wins outright; on contention the pointer decides.
    assign win        = (req0 && req1) ? ptr : req1;
    assign last_issue = (state == BURST) && (remaining == '0);

    // Register FSM state, arbitration state and the issue-side outputs.
    // NOTE: every state-holding assignment in an always_ff is non-blocking,
    // so all registers update together from values of the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            remaining   <= '0;
            rom_enable  <= 1'b0;
            rom_address <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            remaining   <= remaining_nx;
            rom_enable  <= rom_enable_nx;
            rom_address <= rom_address_nx;
            gnt0        <= gnt0_nx;
            gnt1        <= gnt1_nx;
            busy        <= busy_nx;
        end
    end

    // Next state, arbitration and next values of the registered outputs.
    // NOTE: every signal gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        owner_nx       = owner;
        remaining_nx   = remaining;
        rom_enable_nx  = 1'b0;
        rom_address_nx = rom_address;
        gnt0_nx        = 1'b0;
        gnt1_nx        = 1'b0;

        // The pointer moves on the same edge that registers done.
        if (rd_last) begin
            ptr_nx = ~owner;
        end

        case (state)
            IDLE: begin
                // Requests are sampled only here, so a req raised while busy
                // waits until the arbiter is idle again.
                if (req0 || req1) begin
                    owner_nx       = win;
                    rom_address_nx = win ? addr1 : addr0;
                    remaining_nx   = win ? len1 : len0;
                    rom_enable_nx  = 1'b1;
                    gnt0_nx        = ~win;
                    gnt1_nx        = win;
                    state_nx       = BURST;
                end
            end
            BURST: begin
                if (remaining == '0) begin
                    // The final address is on the bus now. Stop issuing and
                    // hold the address while the pipeline drains.
                    state_nx = DRAIN;
                end else begin
                    rom_enable_nx  = 1'b1;
                    rom_address_nx = rom_address + ADDR_W'(1);
                    remaining_nx   = remaining - LEN_W'(1);
                end
            end
            DRAIN: begin
                // Leave once done is on the outputs. busy stays high through
                // the done cycle, and the next IDLE cycle separates bursts.
                if (done0 || done1) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // Return path: register PROM data toward the requester that owns the burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_last <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
        end else begin
            rd_pend <= rom_enable;
            rd_last <= last_issue;
            rvalid0 <= rd_pend && !owner;
            rvalid1 <= rd_pend && owner;
            done0   <= rd_last && !owner;
            done1   <= rd_last && owner;
            if (rd_pend) begin
                rdata <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_prom_read_arbiter.sv
// tb_prom_read_arbiter
// Directed tests for prom_read_arbiter against a behavioural PROM with
// mem[a] = ~a. Each test drives requests and compares the full output
// vector cycle by cycle against a hand-written table. Row 0 of each table
// is the cycle after the edge that samples the request. Don't-care fields
// are masked: rom_address when rom_enable is low, rdata when no rvalid.
module tb_prom_read_arbiter;

    localparam int   ADDR_W = 4;
    localparam int   DATA_W = 4;
    localparam int   LEN_W  = 3;
    localparam logic H      = 1'b1;
    localparam logic L      = 1'b0;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req0  = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [LEN_W-1:0]  len0  = '0;
    logic              req1  = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [LEN_W-1:0]  len1  = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy;
    logic [DATA_W-1:0] rdata;
    logic              rom_enable;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data = '0;

    int passed = 0;
    int total  = 0;

    prom_read_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .addr0      (addr0),
        .len0       (len0),
        .req1       (req1),
        .addr1      (addr1),
        .len1       (len1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .done0      (done0),
        .done1      (done1),
        .busy       (busy),
        .rom_enable (rom_enable),
        .rom_address(rom_address),
        .rom_data   (rom_data)
    );

    always #5 clock = ~clock;

    // Behavioural synchronous PROM: registered output, one-cycle latency.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    initial begin
        for (int a = 0; a < 2**ADDR_W; a++) mem[a] = ~DATA_W'(a);
    end
    always @(posedge clock) begin
        if (rom_enable) rom_data <= mem[rom_address];
    end

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       en;
        logic [3:0] a;
        logic       v0;
        logic       v1;
        logic [3:0] d;
        logic       d0;
        logic       d1;
        logic       b;
    } vec_t;

    function automatic vec_t mk(logic g0, logic g1, logic en, logic [3:0] a,
                                logic v0, logic v1, logic [3:0] d,
                                logic d0, logic d1, logic b);
        vec_t v;
        v.g0 = g0; v.g1 = g1; v.en = en; v.a = a;
        v.v0 = v0; v.v1 = v1; v.d = d;
        v.d0 = d0; v.d1 = d1; v.b = b;
        return v;
    endfunction

    function automatic vec_t canon(vec_t v);
        vec_t r = v;
        if (!r.en) r.a = 4'h0;
        if (!(r.v0 || r.v1)) r.d = 4'h0;
        return r;
    endfunction

    function automatic vec_t observe();
        return mk(gnt0, gnt1, rom_enable, rom_address, rvalid0, rvalid1,
                  rdata, done0, done1, busy);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        vec_t o;
        repeat (2) tick();
        o = observe();
        total++;
        if (o !== '0) $display("FAIL reset_state: got %h expected 0000", o);
        else passed++;
        reset = 1'b0;
        tick();
        o = observe();
        total++;
        if (o !== '0) $display("FAIL idle_after_reset: got %h expected 0000", o);
        else passed++;
    endtask

    task automatic test_wrap();
        vec_t t [6];
        vec_t o;
        t[0] = mk(L, H, H, 4'hE, L, L, 4'h0, L, L, H);
        t[1] = mk(L, L, H, 4'hF, L, L, 4'h0, L, L, H);
        t[2] = mk(L, L, H, 4'h0, L, H, 4'h1, L, L, H);
        t[3] = mk(L, L, L, 4'h0, L, H, 4'h0, L, L, H);
        t[4] = mk(L, L, L, 4'h0, L, H, 4'hF, L, H, H);
        t[5] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        req1 = 1'b1; addr1 = 4'hE; len1 = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) req1 = 1'b0;
            o = observe();
            total++;
            if (canon(o) !== canon(t[i]))
                $display("FAIL wrap row %0d: got %h expected %h", i, canon(o), canon(t[i]));
            else passed++;
        end
    endtask

    task automatic test_single_burst();
        vec_t t [7];
        vec_t o;
        t[0] = mk(H, L, H, 4'h2, L, L, 4'h0, L, L, H);
        t[1] = mk(L, L, H, 4'h3, L, L, 4'h0, L, L, H);
        t[2] = mk(L, L, H, 4'h4, H, L, 4'hD, L, L, H);
        t[3] = mk(L, L, H, 4'h5, H, L, 4'hC, L, L, H);
        t[4] = mk(L, L, L, 4'h0, H, L, 4'hB, L, L, H);
        t[5] = mk(L, L, L, 4'h0, H, L, 4'hA, H, L, H);
        t[6] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        req0 = 1'b1; addr0 = 4'h2; len0 = 3'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            o = observe();
            total++;
            if (canon(o) !== canon(t[i]))
                $display("FAIL single_burst row %0d: got %h expected %h", i, canon(o), canon(t[i]));
            else passed++;
            if (i == 4) begin
                total++;
                if (rom_address !== 4'h5)
                    $display("FAIL drain_addr_hold: got %h expected 5", rom_address);
                else passed++;
            end
        end
    endtask

    task automatic test_simultaneous();
        vec_t t [13];
        vec_t o;
        reset = 1'b1;
        tick();
        o = observe();
        total++;
        if (o !== '0) $display("FAIL re_reset_state: got %h expected 0000", o);
        else passed++;
        reset = 1'b0;
        t[0]  = mk(H, L, H, 4'h8, L, L, 4'h0, L, L, H);
        t[1]  = mk(L, L, H, 4'h9, L, L, 4'h0, L, L, H);
        t[2]  = mk(L, L, L, 4'h0, H, L, 4'h7, L, L, H);
        t[3]  = mk(L, L, L, 4'h0, H, L, 4'h6, H, L, H);
        t[4]  = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        t[5]  = mk(L, H, H, 4'h3, L, L, 4'h0, L, L, H);
        t[6]  = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, H);
        t[7]  = mk(L, L, L, 4'h0, L, H, 4'hC, L, H, H);
        t[8]  = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        t[9]  = mk(H, L, H, 4'h1, L, L, 4'h0, L, L, H);
        t[10] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, H);
        t[11] = mk(L, L, L, 4'h0, H, L, 4'hE, H, L, H);
        t[12] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        req0 = 1'b1; addr0 = 4'h8; len0 = 3'd1;
        req1 = 1'b1; addr1 = 4'h3; len1 = 3'd0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            if (i == 5) req1 = 1'b0;
            if (i == 8) begin
                req0 = 1'b1; req1 = 1'b1; addr0 = 4'h1; len0 = 3'd0;
            end
            if (i == 9) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            o = observe();
            total++;
            if (canon(o) !== canon(t[i]))
                $display("FAIL simultaneous row %0d: got %h expected %h", i, canon(o), canon(t[i]));
            else passed++;
        end
    endtask

    task automatic test_single_word();
        vec_t t [4];
        vec_t o;
        t[0] = mk(H, L, H, 4'h5, L, L, 4'h0, L, L, H);
        t[1] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, H);
        t[2] = mk(L, L, L, 4'h0, H, L, 4'hA, H, L, H);
        t[3] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        req0 = 1'b1; addr0 = 4'h5; len0 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            o = observe();
            total++;
            if (canon(o) !== canon(t[i]))
                $display("FAIL single_word row %0d: got %h expected %h", i, canon(o), canon(t[i]));
            else passed++;
        end
    endtask

    task automatic test_req_during_busy();
        vec_t t [10];
        vec_t o;
        t[0] = mk(H, L, H, 4'h0, L, L, 4'h0, L, L, H);
        t[1] = mk(L, L, H, 4'h1, L, L, 4'h0, L, L, H);
        t[2] = mk(L, L, H, 4'h2, H, L, 4'hF, L, L, H);
        t[3] = mk(L, L, L, 4'h0, H, L, 4'hE, L, L, H);
        t[4] = mk(L, L, L, 4'h0, H, L, 4'hD, H, L, H);
        t[5] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        t[6] = mk(L, H, H, 4'h7, L, L, 4'h0, L, L, H);
        t[7] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, H);
        t[8] = mk(L, L, L, 4'h0, L, H, 4'h8, L, H, H);
        t[9] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        req0 = 1'b1; addr0 = 4'h0; len0 = 3'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            if (i == 1) begin
                req1 = 1'b1; addr1 = 4'h7; len1 = 3'd0;
            end
            if (i == 6) req1 = 1'b0;
            o = observe();
            total++;
            if (canon(o) !== canon(t[i]))
                $display("FAIL req_during_busy row %0d: got %h expected %h", i, canon(o), canon(t[i]));
            else passed++;
        end
    endtask

    task automatic test_reset_mid_burst();
        vec_t t [5];
        vec_t n [4];
        vec_t o;
        t[0] = mk(H, L, H, 4'h3, L, L, 4'h0, L, L, H);
        t[1] = mk(L, L, H, 4'h4, L, L, 4'h0, L, L, H);
        t[2] = mk(L, L, H, 4'h5, H, L, 4'hC, L, L, H);
        t[3] = mk(L, L, H, 4'h6, H, L, 4'hB, L, L, H);
        t[4] = mk(L, L, H, 4'h7, H, L, 4'hA, L, L, H);
        req0 = 1'b1; addr0 = 4'h3; len0 = 3'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            o = observe();
            total++;
            if (canon(o) !== canon(t[i]))
                $display("FAIL long_burst row %0d: got %h expected %h", i, canon(o), canon(t[i]));
            else passed++;
        end
        // Third word is on rdata now; reset must clear everything at once.
        reset = 1'b1;
        #1;
        o = observe();
        total++;
        if (o !== '0) $display("FAIL reset_immediate: got %h expected 0000", o);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            o = observe();
            total++;
            if (o !== '0) $display("FAIL reset_held cycle %0d: got %h expected 0000", i, o);
            else passed++;
        end
        reset = 1'b0;
        req0 = 1'b1; addr0 = 4'h0; len0 = 3'd0;
        n[0] = mk(H, L, H, 4'h0, L, L, 4'h0, L, L, H);
        n[1] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, H);
        n[2] = mk(L, L, L, 4'h0, H, L, 4'hF, H, L, H);
        n[3] = mk(L, L, L, 4'h0, L, L, 4'h0, L, L, L);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            o = observe();
            total++;
            if (canon(o) !== canon(n[i]))
                $display("FAIL after_reset row %0d: got %h expected %h", i, canon(o), canon(n[i]));
            else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_wrap();
        test_single_burst();
        test_simultaneous();
        test_single_word();
        test_req_during_busy();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
